// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side scheduler for the 4-in/32-out flush FIFO.
// Picks normal reads or flushes and buffers captured words downstream.
module fifo_drain_ctrl #(
  parameter int RD_WIDTH   = 32,
  parameter int FIFO_WORDS = 4,
  parameter int OBUF_DEPTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_vld_rd_data,
  input  logic                fifo_empty,
  input  logic                fifo_flush_done,
  input  logic [RD_WIDTH-1:0] fifo_rd_data,
  output logic                fifo_rd,
  output logic                fifo_flush_req,
  input  logic                flush_cmd,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [RD_WIDTH-1:0] m_data,
  output logic                m_flush,
  output logic                flush_busy,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic                ovf_err
);

  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [CW-1:0] DEPTH_C = CW'(OBUF_DEPTH);
  localparam logic [CW-1:0] NEED_C  = CW'(FIFO_WORDS + 1);
  localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT);
  localparam logic [PW-1:0] LAST_C  = PW'(OBUF_DEPTH - 1);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RD_WIDTH:0] mem_q [OBUF_DEPTH];

  logic [CW-1:0] free;
  logic          timeout_hit;
  logic          start_flush;
  logic          rd_req;
  logic          push;
  logic          pop;
  logic          wr_en;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Read/flush decision from registered occupancy and timer.
  always_comb begin
    free        = DEPTH_C - count_q;
    timeout_hit = (TIMEOUT != 0) && (timer_q == TMAX_C);
    start_flush = (state_q == RUN) && (pending_q || timeout_hit)
                  && !fifo_empty && (free >= NEED_C);
    rd_req      = !rst && (state_q == RUN) && fifo_vld_rd_data
                  && (free != '0) && !start_flush;
    push        = (rd_req || (state_q == FLUSH)) && !fifo_empty;
    pop         = (count_q != '0) && m_ready;
  end

  // Scheduler FSM next state, pending flag, stall timer, flush counter.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RUN: begin
        if (start_flush) begin
          state_d   = FLUSH;
          pending_d = 1'b0;
        end else if (flush_cmd) begin
          pending_d = 1'b1;
        end else if (pending_q && fifo_empty) begin
          pending_d = 1'b0;
        end
        if (!fifo_empty && !fifo_vld_rd_data) begin
          timer_d = (timer_q == TMAX_C) ? timer_q : timer_q + TW'(1);
        end else begin
          timer_d = '0;
        end
      end
      FLUSH: begin
        timer_d = '0;
        if (fifo_flush_done) begin
          state_d     = RUN;
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
          pending_d   = flush_cmd;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output buffer pointers, count and overflow flag.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    if (push) begin
      if ((count_q != DEPTH_C) || pop) begin
        wr_en    = 1'b1;
        wr_ptr_d = nxt(wr_ptr_q);
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = nxt(rd_ptr_q);
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pending_q   <= 1'b0;
      timer_q     <= '0;
      flush_cnt_q <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      flush_cnt_q <= flush_cnt_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Buffer storage: {flush tag, data}; contents qualified by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {(state_q == FLUSH), fifo_rd_data};
    end
  end

  assign fifo_rd        = rd_req;
  assign fifo_flush_req = (state_q == FLUSH);
  assign m_valid        = (count_q != '0);
  assign m_data         = m_valid ? mem_q[rd_ptr_q][RD_WIDTH-1:0] : '0;
  assign m_flush        = m_valid & mem_q[rd_ptr_q][RD_WIDTH];
  assign flush_busy     = pending_q | (state_q == FLUSH);
  assign flush_cnt      = flush_cnt_q;
  assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: directed bench with a nibble-FIFO model,
// scoreboard queue of expected output words and a pop monitor.
module tb_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_vld_rd_data;
  logic        fifo_empty;
  logic        fifo_flush_done;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd;
  logic        fifo_flush_req;
  logic        flush_cmd;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_flush;
  logic        flush_busy;
  logic [15:0] flush_cnt;
  logic        ovf_err;

  logic        wr_en;
  logic [3:0]  wr_nib;
  logic        hold_done;
  logic [3:0]  nibs [0:63];
  int          ncnt;

  logic [32:0] sbq [$];
  int          nvec = 0;
  int          nerr = 0;

  fifo_drain_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_vld_rd_data (fifo_vld_rd_data),
    .fifo_empty       (fifo_empty),
    .fifo_flush_done  (fifo_flush_done),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd          (fifo_rd),
    .fifo_flush_req   (fifo_flush_req),
    .flush_cmd        (flush_cmd),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_flush          (m_flush),
    .flush_busy       (flush_busy),
    .flush_cnt        (flush_cnt),
    .ovf_err          (ovf_err)
  );

  always #5 clk = ~clk;

  // Asymmetric FIFO model: first nibble written lands in bits [3:0].
  assign fifo_empty       = (ncnt == 0);
  assign fifo_vld_rd_data = (ncnt >= 8);
  assign fifo_flush_done  = fifo_flush_req & fifo_empty & !hold_done;

  always_comb begin
    fifo_rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      fifo_rd_data[4*i +: 4] = (i < ncnt) ? nibs[i] : 4'h0;
    end
  end

  always @(posedge clk) begin
    int n;
    int k;
    logic [3:0] t [0:63];
    n = ncnt;
    t = nibs;
    if (rst) begin
      n = 0;
    end else begin
      if ((fifo_rd || fifo_flush_req) && n != 0) begin
        k = (n < 8) ? n : 8;
        for (int i = 0; i < 56; i++) t[i] = t[i+k];
        n = n - k;
      end
      if (wr_en) begin
        t[n] = wr_nib;
        n = n + 1;
      end
    end
    ncnt <= n;
    nibs <= t;
  end

  // Monitor: every accepted output word is checked against the queue.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && m_valid && m_ready) begin
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL out_word unexpected: got flush=%0b data=%h", m_flush, m_data);
      end else begin
        e = sbq.pop_front();
        if ({m_flush, m_data} !== e) begin
          nerr++;
          $display("FAIL out_word: got flush=%0b data=%h, want flush=%0b data=%h",
                   m_flush, m_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] v);
    wr_en  = 1'b1;
    wr_nib = v;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic pulse_cmd();
    flush_cmd = 1'b1;
    step();
    flush_cmd = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (flush_busy && c < 100) begin
      step();
      c++;
    end
    chk(nm, flush_busy, 0);
  endtask

  task automatic drain(input string nm);
    int c = 0;
    m_ready = 1'b1;
    while (sbq.size() != 0 && c < 100) begin
      step();
      c++;
    end
    step();
    chk(nm, sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_nib    = '0;
    flush_cmd = 1'b0;
    m_ready   = 1'b0;
    hold_done = 1'b0;
    ncnt      = 0;
    for (int i = 0; i < 64; i++) nibs[i] = '0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_flush_req", fifo_flush_req, 0);
    chk("rst_rd",        fifo_rd, 0);
    chk("rst_m_valid",   m_valid, 0);
    chk("rst_m_data",    m_data, 0);
    chk("rst_busy",      flush_busy, 0);
    chk("rst_cnt",       flush_cnt, 0);
    chk("rst_ovf",       ovf_err, 0);

    // normal reads
    m_ready = 1'b1;
    sbq.push_back({1'b0, 32'h87654321});
    sbq.push_back({1'b0, 32'h87654321});
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 8; i++) wr(4'(i));
    end
    drain("normal_drain");
    chk("normal_cnt", flush_cnt, 0);
    chk("normal_busy", flush_busy, 0);

    // auto flush after stall timeout, measured from first nibble
    sbq.push_back({1'b1, 32'h00000CBA});
    wr(4'hA);
    cyc = 0;
    while (!fifo_flush_req && cyc < 40) begin
      wr_en  = (cyc < 2);
      wr_nib = (cyc == 0) ? 4'hB : 4'hC;
      step();
      cyc++;
    end
    wr_en = 1'b0;
    chk("auto_lat", cyc, 17);
    chk("auto_busy", flush_busy, 1);
    chk("auto_rd", fifo_rd, 0);
    wait_idle("auto_idle");
    chk("auto_cnt", flush_cnt, 1);
    drain("auto_drain");

    // commanded flush with 3 words held and backpressure
    m_ready = 1'b0;
    sbq.push_back({1'b0, 32'h76543210});
    sbq.push_back({1'b0, 32'hFEDCBA98});
    sbq.push_back({1'b0, 32'h76543210});
    sbq.push_back({1'b1, 32'h0000CBA9});
    for (int i = 0; i < 24; i++) wr(4'(i));
    for (int i = 9; i <= 12; i++) wr(4'(i));
    step();
    pulse_cmd();
    chk("cmd_busy", flush_busy, 1);
    step();
    chk("cmd_start", fifo_flush_req, 1);
    wait_idle("cmd_idle");
    chk("cmd_cnt", flush_cnt, 2);
    chk("cmd_ovf", ovf_err, 0);
    chk("cmd_valid", m_valid, 1);
    drain("cmd_drain");

    // gated flush: 5 words held leaves free=3
    m_ready = 1'b0;
    sbq.push_back({1'b0, 32'h76543210});
    sbq.push_back({1'b0, 32'hFEDCBA98});
    sbq.push_back({1'b0, 32'h76543210});
    sbq.push_back({1'b0, 32'hFEDCBA98});
    sbq.push_back({1'b0, 32'h76543210});
    sbq.push_back({1'b1, 32'h00000321});
    for (int i = 0; i < 40; i++) wr(4'(i));
    for (int i = 1; i <= 3; i++) wr(4'(i));
    pulse_cmd();
    for (int i = 0; i < 25; i++) step();
    chk("gate_busy", flush_busy, 1);
    chk("gate_noreq", fifo_flush_req, 0);
    m_ready = 1'b1;
    step();
    step();
    m_ready = 1'b0;
    chk("gate_free5", fifo_flush_req, 0);
    step();
    chk("gate_start", fifo_flush_req, 1);
    wait_idle("gate_idle");
    chk("gate_cnt", flush_cnt, 3);
    chk("gate_ovf", ovf_err, 0);
    drain("gate_drain");

    // flush command with nothing to flush
    pulse_cmd();
    chk("empty_pend", flush_busy, 1);
    step();
    chk("empty_clr", flush_busy, 0);
    chk("empty_noreq", fifo_flush_req, 0);
    step();
    step();
    chk("empty_cnt", flush_cnt, 3);

    // reset in the middle of a flush
    m_ready   = 1'b0;
    hold_done = 1'b1;
    wr(4'h5);
    wr(4'h6);
    pulse_cmd();
    step();
    step();
    chk("mid_inflush", fifo_flush_req, 1);
    chk("mid_valid", m_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_done = 1'b0;
    sbq.delete();
    chk("mid_req", fifo_flush_req, 0);
    chk("mid_mvalid", m_valid, 0);
    chk("mid_cnt", flush_cnt, 0);
    chk("mid_ovf", ovf_err, 0);
    chk("mid_busy", flush_busy, 0);

    // controller back in RUN: a normal read follows
    m_ready = 1'b1;
    sbq.push_back({1'b0, 32'h76543210});
    for (int i = 0; i < 8; i++) wr(4'(i));
    drain("post_drain");
    chk("post_cnt", flush_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
